// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : md_pkg
//  Purpose  : Shared op encodings, default latencies and helpers for md_unit.
//  Revision : 1.0  initial release
// ============================================================================
package md_pkg;

    typedef logic [2:0] md_op_t;

    localparam md_op_t MD_NONE  = 3'd0;
    localparam md_op_t MD_MULT  = 3'd1;
    localparam md_op_t MD_MULTU = 3'd2;
    localparam md_op_t MD_DIV   = 3'd3;
    localparam md_op_t MD_DIVU  = 3'd4;
    localparam md_op_t MD_MTHI  = 3'd5;
    localparam md_op_t MD_MTLO  = 3'd6;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // Bits needed to hold a down-counter starting at n.
    function automatic int md_cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

    localparam int MD_CNT_W = md_cnt_width(MD_DIV_CYCLES_DEF);

    function automatic logic md_is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_arith(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op);
    endfunction

endpackage : md_pkg
`default_nettype wire

// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : md_unit_if
//  Purpose  : EX-stage issue/result bundle between the pipeline and md_unit.
//  Revision : 1.0  initial release
// ============================================================================
interface md_unit_if;

    logic                 start;
    md_pkg::md_op_t       md_op;
    logic [31:0]          a;
    logic [31:0]          b;
    logic                 req;
    logic                 busy;
    logic [31:0]          hi;
    logic [31:0]          lo;

    modport master (
        output start, md_op, a, b, req,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, a, b, req,
        output busy, hi, lo
    );

endinterface : md_unit_if
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
//  Module   : md_arith
//  Purpose  : Combinational multiply/divide datapath producing {hi,lo}.
//  Revision : 1.0  initial release
// ============================================================================
module md_arith
    import md_pkg::*;
(
    input  wire md_op_t       i_op,
    input  wire logic [31:0]  i_a,
    input  wire logic [31:0]  i_b,
    output logic [63:0]       o_result,
    output logic              o_hold
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_signed_div;
    logic               w_neg_a;
    logic               w_neg_b;
    logic        [31:0] w_mag_a;
    logic        [31:0] w_mag_b;
    logic        [31:0] w_dvsr;
    logic        [31:0] w_q_mag;
    logic        [31:0] w_r_mag;
    logic        [31:0] w_quot;
    logic        [31:0] w_rem;
    logic               w_div_zero;

    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide runs on magnitudes so the unsigned divider is shared;
    // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    assign w_signed_div = (i_op == MD_DIV);
    assign w_neg_a      = w_signed_div & i_a[31];
    assign w_neg_b      = w_signed_div & i_b[31];
    assign w_mag_a      = w_neg_a ? (32'd0 - i_a) : i_a;
    assign w_mag_b      = w_neg_b ? (32'd0 - i_b) : i_b;
    assign w_div_zero   = (i_b == 32'd0);
    assign w_dvsr       = w_div_zero ? 32'd1 : w_mag_b;
    assign w_q_mag      = w_mag_a / w_dvsr;
    assign w_r_mag      = w_mag_a % w_dvsr;
    assign w_quot       = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem        = w_neg_a ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        o_result = 64'd0;
        case (i_op)
            MD_MULT:          o_result = w_prod_s;
            MD_MULTU:         o_result = w_prod_u;
            MD_DIV, MD_DIVU:  o_result = {w_rem, w_quot};
            default:          o_result = 64'd0;
        endcase
    end

    assign o_hold = md_is_div(i_op) & w_div_zero;

endmodule : md_arith
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : md_unit
//  Purpose  : Multi-cycle multiply/divide unit with HI/LO registers (EX stage).
//  Revision : 1.0  initial release
// ============================================================================
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
)(
    input  wire logic   clk,
    input  wire logic   reset,
    md_unit_if.slave    bus
);

    localparam int C_MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int C_CNT_W      = md_cnt_width(C_MAX_CYCLES);

    localparam logic [C_CNT_W-1:0] C_MULT_LOAD = C_CNT_W'(MULT_CYCLES);
    localparam logic [C_CNT_W-1:0] C_DIV_LOAD  = C_CNT_W'(DIV_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [C_CNT_W-1:0]   w_cnt_nx;
    md_op_t               r_op;
    md_op_t               w_op_nx;
    logic [31:0]          r_a;
    logic [31:0]          w_a_nx;
    logic [31:0]          r_b;
    logic [31:0]          w_b_nx;
    logic [31:0]          r_hi;
    logic [31:0]          w_hi_nx;
    logic [31:0]          r_lo;
    logic [31:0]          w_lo_nx;

    logic [63:0]          w_result;
    logic                 w_hold;

    md_arith u_arith (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_result),
        .o_hold   (w_hold)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= MD_NONE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_op    <= w_op_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_hi    <= w_hi_nx;
            r_lo    <= w_lo_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_op_nx    = r_op;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_hi_nx    = r_hi;
        w_lo_nx    = r_lo;

        case (r_state)
            S_IDLE: begin
                if (!bus.req) begin
                    if (bus.start && md_is_arith(bus.md_op)) begin
                        w_op_nx    = bus.md_op;
                        w_a_nx     = bus.a;
                        w_b_nx     = bus.b;
                        w_cnt_nx   = md_is_div(bus.md_op) ? C_DIV_LOAD : C_MULT_LOAD;
                        w_state_nx = S_RUN;
                    end else if (bus.md_op == MD_MTHI) begin
                        w_hi_nx = bus.a;
                    end else if (bus.md_op == MD_MTLO) begin
                        w_lo_nx = bus.a;
                    end
                end
            end

            S_RUN: begin
                // Issue-side inputs are deliberately ignored while running.
                if (r_cnt == C_CNT_ONE) begin
                    if (!w_hold) begin
                        w_hi_nx = w_result[63:32];
                        w_lo_nx = w_result[31:0];
                    end
                    w_cnt_nx   = '0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - C_CNT_ONE;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule : md_unit
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_unit
//  Purpose  : Directed self-checking bench for md_unit with a timing model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_md_unit;
    import md_pkg::*;

    localparam int C_MULT = 5;
    localparam int C_DIV  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    md_unit_if u_if ();

    md_unit #(
        .MULT_CYCLES (C_MULT),
        .DIV_CYCLES  (C_DIV)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (u_if.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: absolute edge count and the edge at which the unit frees.
    logic [31:0] m_hi     = 32'd0;
    logic [31:0] m_lo     = 32'd0;
    longint      cyc      = 0;
    longint      due      = 0;
    logic        m_pend_v = 1'b0;
    logic [63:0] m_pend   = 64'd0;

    function automatic logic [63:0] ref_result(input md_op_t op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          q;
        longint          r;
        longint unsigned uq;
        longint unsigned ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MD_MULT:  return sa * sb;
            MD_MULTU: return ua * ub;
            MD_DIV: begin
                if (b == 32'd0) return 64'd0;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            MD_DIVU: begin
                if (b == 32'd0) return 64'd0;
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default:  return 64'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        bit idle_before;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_hi     = 32'd0;
                m_lo     = 32'd0;
                due      = cyc;
                m_pend_v = 1'b0;
            end else begin
                idle_before = (cyc >= due);
                cyc++;
                if (!idle_before && cyc == due && m_pend_v) begin
                    {m_hi, m_lo} = m_pend;
                    m_pend_v     = 1'b0;
                end
                if (idle_before && !u_if.req) begin
                    if (u_if.start && md_is_arith(u_if.md_op)) begin
                        due      = cyc + (md_is_div(u_if.md_op) ? C_DIV : C_MULT);
                        m_pend   = ref_result(u_if.md_op, u_if.a, u_if.b);
                        m_pend_v = !(md_is_div(u_if.md_op) && u_if.b == 32'd0);
                    end else if (u_if.md_op == MD_MTHI) begin
                        m_hi = u_if.a;
                    end else if (u_if.md_op == MD_MTLO) begin
                        m_lo = u_if.a;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("model busy", {31'd0, u_if.busy}, {31'd0, (cyc < due)});
                check("model hi", u_if.hi, m_hi);
                check("model lo", u_if.lo, m_lo);
            end
        end
    end

    task automatic issue(input bit s, input md_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input bit r);
        u_if.start = s;
        u_if.md_op = op;
        u_if.a     = a;
        u_if.b     = b;
        u_if.req   = r;
        @(negedge clk);
        u_if.start = 1'b0;
        u_if.md_op = MD_NONE;
        u_if.a     = 32'd0;
        u_if.b     = 32'd0;
        u_if.req   = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        u_if.start = 1'b0;
        u_if.md_op = MD_NONE;
        u_if.a     = 32'd0;
        u_if.b     = 32'd0;
        u_if.req   = 1'b0;
        cycles(2);
        #2 rst = 1'b0;
        @(negedge clk);
        check("reset busy", {31'd0, u_if.busy}, 32'd0);
        check("reset hi", u_if.hi, 32'd0);
        check("reset lo", u_if.lo, 32'd0);

        // mult -2 * 3
        issue(1'b1, MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult busy first", {31'd0, u_if.busy}, 32'd1);
        cycles(4);
        check("mult busy last", {31'd0, u_if.busy}, 32'd1);
        check("mult hi held", u_if.hi, 32'd0);
        cycles(1);
        check("mult busy done", {31'd0, u_if.busy}, 32'd0);
        check("mult hi", u_if.hi, 32'hFFFF_FFFF);
        check("mult lo", u_if.lo, 32'hFFFF_FFFA);

        issue(1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        cycles(5);
        check("multu hi", u_if.hi, 32'h0000_0001);
        check("multu lo", u_if.lo, 32'hFFFF_FFFE);

        issue(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        cycles(9);
        check("div busy last", {31'd0, u_if.busy}, 32'd1);
        cycles(1);
        check("div lo", u_if.lo, 32'hFFFF_FFFD);
        check("div hi", u_if.hi, 32'hFFFF_FFFF);

        issue(1'b1, MD_DIVU, 32'd7, 32'd0, 1'b0);
        cycles(9);
        check("div0 busy last", {31'd0, u_if.busy}, 32'd1);
        cycles(1);
        check("div0 busy done", {31'd0, u_if.busy}, 32'd0);
        check("div0 hi kept", u_if.hi, 32'hFFFF_FFFF);
        check("div0 lo kept", u_if.lo, 32'hFFFF_FFFD);

        issue(1'b0, MD_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        check("mthi hi", u_if.hi, 32'h1234_5678);
        check("mthi busy", {31'd0, u_if.busy}, 32'd0);
        issue(1'b0, MD_MTLO, 32'h9ABC_DEF0, 32'd0, 1'b0);
        check("mtlo lo", u_if.lo, 32'h9ABC_DEF0);
        check("mtlo hi kept", u_if.hi, 32'h1234_5678);

        // req flushes the issuing instruction
        issue(1'b1, MD_MULT, 32'd3, 32'd3, 1'b1);
        check("req busy", {31'd0, u_if.busy}, 32'd0);
        issue(1'b0, MD_MTHI, 32'h5555_AAAA, 32'd0, 1'b1);
        check("req hi kept", u_if.hi, 32'h1234_5678);
        check("req lo kept", u_if.lo, 32'h9ABC_DEF0);

        // ops arriving mid-run are dropped
        issue(1'b1, MD_DIV, 32'd100, 32'd7, 1'b0);
        cycles(2);
        issue(1'b1, MD_MULT, 32'd9, 32'd9, 1'b0);
        issue(1'b0, MD_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0);
        cycles(5);
        check("run busy", {31'd0, u_if.busy}, 32'd1);
        check("run lo stable", u_if.lo, 32'h9ABC_DEF0);
        cycles(1);
        check("run div lo", u_if.lo, 32'd14);
        check("run div hi", u_if.hi, 32'd2);
        check("run not restarted", {31'd0, u_if.busy}, 32'd0);

        issue(1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        cycles(10);
        check("ovf lo", u_if.lo, 32'h8000_0000);
        check("ovf hi", u_if.hi, 32'd0);

        issue(1'b1, MD_MULT, 32'd5, 32'd5, 1'b0);
        cycles(2);
        #2 rst = 1'b1;
        #1;
        check("abort busy", {31'd0, u_if.busy}, 32'd0);
        check("abort hi", u_if.hi, 32'd0);
        check("abort lo", u_if.lo, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        issue(1'b1, MD_MULTU, 32'd3, 32'd4, 1'b0);
        cycles(5);
        check("post-reset lo", u_if.lo, 32'd12);
        check("post-reset hi", u_if.hi, 32'd0);

        // accepted on the first idle cycle
        issue(1'b1, MD_MULT, 32'd7, 32'hFFFF_FFFF, 1'b0);
        check("b2b busy", {31'd0, u_if.busy}, 32'd1);
        cycles(5);
        check("b2b hi", u_if.hi, 32'hFFFF_FFFF);
        check("b2b lo", u_if.lo, 32'hFFFF_FFF9);

        cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_md_unit
`default_nettype wire
